cache_axi_arbiter: RTL

Parametrised N-port arbiter between the private caches and one AXI4 master port, moving whole cache lines as INCR bursts. Each cache raises a line-load or line-store command; the block grants one port at a time (round-robin or fixed priority), runs the full AR/R or AW/W/B exchange, and returns the line or store completion with a response-error flag. It sits between the cache array and the memory interconnect, one instance per core cluster.

---
 rtl/cache_axi_arbiter.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/cache_axi_arbiter.sv
// cache_axi_arbiter
// -----------------
// Shares one AXI4 master port among CONNECTIONS private caches. Each port
// issues a whole-line load or store. The block grants one port at a time,
// runs a single INCR burst of BEATS beats (AR/R or AW/W/B), and returns the
// line or the store completion together with a sticky response-error flag.
//
// Optional feature macro: CACHE_AXI_ARB_RR_EN
//   defined   -> round-robin grant starting at the priority pointer
//   undefined -> fixed priority, lowest valid index wins, pointer held at 0
//
// Ports
//   clk, reset                 clock (rising edge), asynchronous active-low reset
//   command_valid/store/rready per-port request, direction, result acceptance
//   command_addr, data_in      per-port line address and store line
//   bus_ready                  one-hot, one-cycle command-accept pulse (IDLE only)
//   bus_valid, bus_err         one-hot result valid, sticky error for that result
//   cacheID, data_out          owning port, returned (or written) line
//   m_axi_*                    AXI4 master read and write channels
module cache_axi_arbiter #(
    parameter  int DATA_WIDTH  = 64,
    parameter  int ADDR_WIDTH  = 64,
    parameter  int CHUNKS_LOG  = 3,
    parameter  int CONNECTIONS = 4,
    localparam int BEATS       = 2 ** CHUNKS_LOG,
    localparam int LINE        = DATA_WIDTH * BEATS,
    localparam int IW          = $clog2(CONNECTIONS)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [CONNECTIONS-1:0]                 command_valid,
    input  logic [CONNECTIONS-1:0]                 command_store,
    input  logic [CONNECTIONS-1:0]                 command_rready,
    input  logic [CONNECTIONS-1:0][ADDR_WIDTH-1:0] command_addr,
    input  logic [CONNECTIONS-1:0][LINE-1:0]       data_in,
    output logic [CONNECTIONS-1:0]                 bus_ready,
    output logic [CONNECTIONS-1:0]                 bus_valid,
    output logic                                   bus_err,
    output logic [IW-1:0]                          cacheID,
    output logic [LINE-1:0]                        data_out,
    output logic [ADDR_WIDTH-1:0]                  m_axi_araddr,
    output logic [7:0]                             m_axi_arlen,
    output logic [2:0]                             m_axi_arsize,
    output logic [1:0]                             m_axi_arburst,
    output logic                                   m_axi_arlock,
    output logic [3:0]                             m_axi_arcache,
    output logic [2:0]                             m_axi_arprot,
    output logic                                   m_axi_arvalid,
    input  logic                                   m_axi_arready,
    input  logic [DATA_WIDTH-1:0]                  m_axi_rdata,
    input  logic [1:0]                             m_axi_rresp,
    input  logic                                   m_axi_rlast,
    input  logic                                   m_axi_rvalid,
    output logic                                   m_axi_rready,
    output logic [ADDR_WIDTH-1:0]                  m_axi_awaddr,
    output logic [7:0]                             m_axi_awlen,
    output logic [2:0]                             m_axi_awsize,
    output logic [1:0]                             m_axi_awburst,
    output logic                                   m_axi_awlock,
    output logic [3:0]                             m_axi_awcache,
    output logic [2:0]                             m_axi_awprot,
    output logic                                   m_axi_awvalid,
    input  logic                                   m_axi_awready,
    output logic [DATA_WIDTH-1:0]                  m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]                m_axi_wstrb,
    output logic                                   m_axi_wlast,
    output logic                                   m_axi_wvalid,
    input  logic                                   m_axi_wready,
    input  logic [1:0]                             m_axi_bresp,
    input  logic                                   m_axi_bvalid,
    output logic                                   m_axi_bready
);

    typedef enum logic [2:0] {
        S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE
    } state_e;

    localparam int                     OFF        = $clog2(LINE / 8);
    localparam logic [ADDR_WIDTH-1:0]  ALIGN_MASK = ~((ADDR_WIDTH'(1) << OFF) - ADDR_WIDTH'(1));
    localparam logic [CHUNKS_LOG-1:0]  LAST_BEAT  = CHUNKS_LOG'(BEATS - 1);

    state_e                 state_q, state_d;
    logic [IW-1:0]          ptr_q, ptr_d;
    logic [CHUNKS_LOG-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]          id_q, id_d;
    logic                   err_q, err_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [LINE-1:0]        line_q, line_d;

    logic [IW-1:0]          grant;
    logic                   any_valid;
    logic                   last_beat;

    // Only the error bit of each response is meaningful here.
    logic                   unused_resp_bits;
    assign unused_resp_bits = ^{m_axi_rresp[0], m_axi_bresp[0]};

    assign last_beat = (cnt_q == LAST_BEAT);

    // Grant selection. The loop runs from the far end down so the last match
    // written is the one closest to the scan start.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        any_valid = |command_valid;
`ifdef CACHE_AXI_ARB_RR_EN
        for (int i = CONNECTIONS - 1; i >= 0; i--) begin
            idx = int'(ptr_q) + i;
            if (idx >= CONNECTIONS) begin
                idx = idx - CONNECTIONS;
            end
            if (command_valid[idx]) begin
                grant = IW'(idx);
            end
        end
`else
        for (int i = CONNECTIONS - 1; i >= 0; i--) begin
            if (command_valid[i]) begin
                grant = IW'(i);
            end
        end
`endif
    end

    // Next-state logic. The burst length is fixed, so the beat counter alone
    // decides when a read ends; a misplaced rlast is only reported as an error.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        err_d   = err_q;
        addr_d  = addr_q;
        line_d  = line_q;
        case (state_q)
            S_IDLE: begin
                if (any_valid) begin
                    addr_d  = command_addr[grant] & ALIGN_MASK;
                    line_d  = data_in[grant];
                    id_d    = grant;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = command_store[grant] ? S_AW : S_AR;
                end
            end
            S_AR: begin
                if (m_axi_arready) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                if (m_axi_rvalid) begin
                    line_d[int'(cnt_q) * DATA_WIDTH +: DATA_WIDTH] = m_axi_rdata;
                    if (m_axi_rresp[1] || (m_axi_rlast != last_beat)) begin
                        err_d = 1'b1;
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (last_beat) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_AW: begin
                if (m_axi_awready) begin
                    state_d = S_W;
                end
            end
            S_W: begin
                if (m_axi_wready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_beat) begin
                        state_d = S_B;
                    end
                end
            end
            S_B: begin
                if (m_axi_bvalid) begin
                    err_d   = err_q | m_axi_bresp[1];
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (command_rready[id_q]) begin
                    state_d = S_IDLE;
`ifdef CACHE_AXI_ARB_RR_EN
                    ptr_d = (id_q == IW'(CONNECTIONS - 1)) ? '0 : id_q + 1'b1;
`else
                    ptr_d = '0;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            id_q    <= '0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
        end
    end

    // bus_ready is the only output not decoded from registered state; it is
    // also held low while reset is asserted so a waiting cache sees nothing.
    assign bus_ready = (state_q == S_IDLE && reset && any_valid)
                       ? (CONNECTIONS'(1) << grant) : '0;
    assign bus_valid = (state_q == S_DONE) ? (CONNECTIONS'(1) << id_q) : '0;
    assign bus_err   = err_q;
    assign cacheID   = id_q;
    assign data_out  = (state_q == S_DONE) ? line_q : '0;

    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = 8'(BEATS - 1);
    assign m_axi_arsize  = 3'($clog2(DATA_WIDTH / 8));
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = (state_q == S_AR);
    assign m_axi_rready  = (state_q == S_R);

    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = 8'(BEATS - 1);
    assign m_axi_awsize  = 3'($clog2(DATA_WIDTH / 8));
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = (state_q == S_AW);
    assign m_axi_wvalid  = (state_q == S_W);
    assign m_axi_wlast   = (state_q == S_W) && last_beat;
    assign m_axi_wdata   = (state_q == S_W) ? line_q[int'(cnt_q) * DATA_WIDTH +: DATA_WIDTH] : '0;
    assign m_axi_wstrb   = '1;
    assign m_axi_bready  = (state_q == S_B);

endmodule
